// File: rtl/alu_seq.sv
// alu_seq: registered ALU with NZCV flags, iterative MUL and valid/ready handshakes on both sides.
// Ports: clk, reset_n, in_valid/in_ready, a, b, op, set_flags, out_valid/out_ready, result, flags, busy.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_ADC = 3'b101;
  localparam logic [2:0] OP_SBC = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             mul_s;

  logic             accept;
  logic             mul_op;
  logic             arith;
  logic             inv_b;
  logic             cin;
  logic [WIDTH-1:0] bb;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_r;
  logic [3:0]       alu_f;
  logic [WIDTH-1:0] acc_nx;
  logic [3:0]       mul_f;

  assign in_ready = (state == IDLE)
                  && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_op   = (op == OP_MUL) && (MUL_EN != 0);

  // Without MUL, opcode 111 falls through as a plain ADD.
  always_comb begin
    arith = 1'b0;
    inv_b = 1'b0;
    cin   = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): arith = 1'b1;
      (op == OP_SUB): begin
        arith = 1'b1;
        inv_b = 1'b1;
        cin   = 1'b1;
      end
      (op == OP_ADC): begin
        arith = 1'b1;
        cin   = flags[1];
      end
      (op == OP_SBC): begin
        arith = 1'b1;
        inv_b = 1'b1;
        cin   = flags[1];
      end
      (op == OP_MUL): arith = !mul_op;
      default: arith = 1'b0;
    endcase
  end

  assign bb  = inv_b ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bb}
             + {{WIDTH{1'b0}}, cin};

  always_comb begin
    alu_r = sum[WIDTH-1:0];
    unique case (1'b1)
      (op == OP_AND): alu_r = a & b;
      (op == OP_ORR): alu_r = a | b;
      (op == OP_EOR): alu_r = a ^ b;
      default: alu_r = sum[WIDTH-1:0];
    endcase
  end

  // Logical ops keep C and V from the flag register.
  always_comb begin
    alu_f[3] = alu_r[WIDTH-1];
    alu_f[2] = (alu_r == '0);
    alu_f[1] = flags[1];
    alu_f[0] = flags[0];
    if (arith) begin
      alu_f[1] = sum[WIDTH];
      alu_f[0] = (a[WIDTH-1] == bb[WIDTH-1])
              && (sum[WIDTH-1] != a[WIDTH-1]);
    end
  end

  // Last iteration folds its partial product straight into the result.
  assign acc_nx = mplier[0] ? acc + mcand : acc;

  always_comb begin
    mul_f[3] = acc_nx[WIDTH-1];
    mul_f[2] = (acc_nx == '0);
    mul_f[1] = flags[1];
    mul_f[0] = flags[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      result    <= '0;
      out_valid <= 1'b0;
      flags     <= 4'b0000;
      busy      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      mul_s     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && mul_op) begin
            state     <= MUL_BUSY;
            busy      <= 1'b1;
            acc       <= '0;
            mcand     <= a;
            mplier    <= b;
            cnt       <= '0;
            mul_s     <= set_flags;
            out_valid <= 1'b0;
          end else if (accept) begin
            result    <= alu_r;
            out_valid <= 1'b1;
            if (set_flags) begin
              flags <= alu_f;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL_BUSY: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            result    <= acc_nx;
            out_valid <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            if (mul_s) begin
              flags <= mul_f;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU for the multicycle ARM core.
- Adds EOR, ADC and SBC to ADD/SUB/AND/ORR.
- Adds an iterative shift-add MUL.
- Holds an internal NZCV flag register updated under an S-bit.
- Sits between decode/register-read and writeback; uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- MUL_EN, 1, 1 = MUL implemented iteratively; 0 = opcode 3'b111 behaves as ADD.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 ADC, 110 SBC, 111 MUL.
- set_flags  input  1  update flag register with this result (ARM S-bit).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered result.
- flags  output  4  flag register: [3]=N, [2]=Z, [1]=C, [0]=V.
- busy  output  1  high while a MUL iterates.

Behaviour:
- Reset (async, reset_n=0): state IDLE, result=0, out_valid=0, flags=4'b0000, busy=0, iteration counter=0.
  - Takes effect immediately, including mid-MUL; the partial product is discarded.
- Acceptance: on a rising edge with in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Back-to-back single-cycle ops stream at 1 per cycle when out_ready is held high.
- Output hold: out_valid stays high and result stays stable until the out_valid && out_ready edge.
  - out_valid drops on that edge unless a new single-cycle op is accepted on the same edge; in that case out_valid stays high with the new result.
- Single-cycle ops: result and out_valid are registered on the accepting edge (latency 1).
- Arithmetic: computed at WIDTH+1 bits; result = low WIDTH bits.
  - ADD: a+b.
  - SUB: a+~b+1.
  - ADC: a+b+C.
  - SBC: a+~b+C.
  - C = carry out of bit WIDTH-1. For SUB/SBC, C=1 means no borrow (ARM convention).
  - V = the two addend MSBs are equal and differ from result MSB. The addends are a and b (ADD/ADC) or a and ~b (SUB/SBC).
- Logical ops (AND, ORR, EOR) and MUL: only N and Z are updated; C and V keep their previous values.
- N = result[WIDTH-1]. Z = (result==0).
- Flags update on the same edge the result is registered, and only if the latched set_flags=1. Otherwise flags are unchanged.
  - ADC/SBC use the C value in the flag register at the accepting edge.
- MUL (MUL_EN=1): FSM IDLE -> MUL_BUSY -> IDLE.
  - The accepting edge latches a, b and set_flags, clears the accumulator, sets counter=0, enters MUL_BUSY and raises busy.
  - Each MUL_BUSY cycle: if multiplier LSB is 1, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++.
  - On the edge where counter reaches WIDTH-1: result = accumulator (low WIDTH bits, modulo 2^WIDTH), out_valid=1, flags updated, state -> IDLE, busy=0.
  - Total latency: WIDTH cycles from acceptance to out_valid.
  - in_ready=0 throughout MUL_BUSY.
- MUL when out_valid is pending: cannot be accepted until the prior result is consumed, because in_ready requires !out_valid || out_ready.
- Inputs a, b, op and set_flags are sampled only at acceptance; changes afterwards have no effect.
- in_valid while in_ready=0 is ignored (no queueing). The requester must hold the request.

Test Plan:
- Reset, then ADD with WIDTH=32, a=32'h7FFFFFFF, b=1, set_flags=1 -> next cycle result=32'h80000000, flags=4'b1001 (N=1, V=1).
- SUB a=5, b=5, S=1 -> result=0, flags=4'b0110 (Z, C=no borrow). Then SBC a=5, b=5, S=1 -> result=0, flags=4'b0110, since SBC uses C=1 from the prior SUB.
- ADD 32'hFFFFFFFF+1 with S=1 (flags=4'b0110), then EOR a=32'hF0, b=32'hFF, S=1 -> result=32'h0F, flags=4'b0010 (C preserved, V preserved).
- MUL a=32'd12345, b=32'd678, out_ready=1 -> busy for 32 cycles, in_ready=0 throughout, out_valid exactly 32 cycles after acceptance with result=32'd8369910. Repeat with WIDTH=8: a=8'd20, b=8'd20 -> result=8'h90 after 8 cycles, N=1.
- Backpressure: hold out_ready=0 after one ADD -> result stable, in_ready=0, a second request is not taken. Raise out_ready -> second op accepted on the consume edge, and out_valid stays continuously high.
- Drive reset_n=0 mid-MUL (cycle 10 of 32) -> out_valid=0, busy=0, flags=0 immediately. After release, a new ADD completes normally with latency 1.
